mem_access_stage: RTL

//  MEM pipeline stage between the EX/MEM register and MEM_WB_Reg. Drives a req/ack data-memory port
//  for loads/stores, stalls upstream stages while an access is outstanding, and presents inst, WB

---
 rtl/mem_access_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory port, upstream stall, timeout watchdog,
// alignment/illegal-op check, and the MEM_WB_Reg result bundle.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   inst_i, WB_signal_i, M_signal_i, ALUResult_i, RTdata_i : from EX/MEM
//   mem_ack_i, mem_rdata_i : memory response
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o : memory request
//   stall_o : hold PC, IF/ID, ID/EX, EX/MEM
//   inst_o, WB_signal_o, MEMdata_o, ALUResult_o : to MEM_WB_Reg
//   err_o : sticky misaligned / illegal / timeout flag
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] inst_i,
  input  logic [1:0]  WB_signal_i,
  input  logic [1:0]  M_signal_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RTdata_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_o,
  output logic [31:0] inst_o,
  output logic [1:0]  WB_signal_o,
  output logic [31:0] MEMdata_o,
  output logic [31:0] ALUResult_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] TO    = 8'(TIMEOUT);
  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    stall       = 1'b0;
    WB_signal_o = WB_signal_i;
    unique case (state_q)
      IDLE: begin
        if (M_signal_i != 2'b00) begin
          WB_signal_o = 2'b00;
          if (M_signal_i == 2'b11 ||
              ALUResult_i[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else begin
            stall   = 1'b1;
            req_d   = 1'b1;
            we_d    = M_signal_i[0];
            addr_d  = {ALUResult_i[31:2], 2'b00};
            wdata_d = RTdata_i;
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall       = 1'b1;
        WB_signal_o = 2'b00;
        if (cnt_q != TO) cnt_d = cnt_q + 8'd1;
        // An ack on the last allowed cycle still counts.
        if (mem_ack_i) begin
          req_d = 1'b0;
          if (!we_q) rdata_d = mem_rdata_i;
          state_d = DONE;
        end else if (cnt_q == TO_M1) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Upstream must never see a stall while reset is held.
  assign stall_o     = stall & ~rst_i;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign inst_o      = inst_i;
  assign ALUResult_o = ALUResult_i;
  assign MEMdata_o   = rdata_q;
  assign err_o       = err_q;

endmodule
